// File: rtl/heightmap_pixel_drain.sv
// heightmap_pixel_drain
// Walks a finished DIM x DIM heightmap in row-major order through a
// synchronous read port and streams one (x, y, z) pixel per point over a
// valid/ready handshake. Reads are credit-limited so that every returned
// word always has a slot: a 2-entry skid FIFO plus the output register.

module heightmap_pixel_drain #(
   parameter int unsigned DIM_POWER = 3,
   parameter logic [9:0]  X_ORIGIN  = 10'd0,
   parameter logic [9:0]  Y_ORIGIN  = 10'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       rd_en,
   output logic [8:0] rd_col,
   output logic [8:0] rd_row,
   input  logic [7:0] rd_data,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic [7:0] z,
   output logic       frame_done
);

   localparam int unsigned DIM      = (32'd1 << DIM_POWER) + 32'd1;
   localparam logic [8:0]  LAST_IDX = 9'(DIM - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Packs a returned height with its screen coordinates; sums wrap mod 1024.
   function automatic logic [27:0] make_word(input logic [8:0] col,
                                             input logic [8:0] row,
                                             input logic [7:0] data);
      logic [9:0] xs;
      logic [9:0] ys;
      xs = X_ORIGIN + {1'b0, col};
      ys = Y_ORIGIN + {1'b0, row};
      return {xs, ys, data};
   endfunction

   state_t      state_r,      state_s;
   logic        busy_r,       busy_s;
   logic        frame_done_r, frame_done_s;
   logic        rd_en_r,      rd_en_s;
   logic [8:0]  rd_col_r,     rd_col_s;
   logic [8:0]  rd_row_r,     rd_row_s;
   logic        inflight_r;
   logic [8:0]  tag_col_r;
   logic [8:0]  tag_row_r;
   logic [27:0] fifo0_r,      fifo0_s;
   logic [27:0] fifo1_r,      fifo1_s;
   logic [1:0]  fifo_cnt_r,   fifo_cnt_s;
   logic        pix_valid_r,  pix_valid_s;
   logic [27:0] pix_word_r,   pix_word_s;

   logic        hs_s;
   logic        load_out_s;
   logic        push_s;
   logic [27:0] in_word_s;
   logic [2:0]  total_s;
   logic        credit_ok_s;
   logic        at_last_s;

   // Next-state, address walk, skid FIFO and output register update.
   always_comb begin
      state_s      = state_r;
      busy_s       = busy_r;
      frame_done_s = 1'b0;
      rd_en_s      = 1'b0;
      rd_col_s     = rd_col_r;
      rd_row_s     = rd_row_r;
      fifo0_s      = fifo0_r;
      fifo1_s      = fifo1_r;
      fifo_cnt_s   = fifo_cnt_r;
      pix_valid_s  = pix_valid_r;
      pix_word_s   = pix_word_r;
      push_s       = inflight_r;

      hs_s       = pix_valid_r & pix_ready;
      load_out_s = ~pix_valid_r | hs_s;
      in_word_s  = make_word(tag_col_r, tag_row_r, rd_data);
      at_last_s  = (rd_col_r == LAST_IDX) && (rd_row_r == LAST_IDX);

      // Items that will still need a slot after this edge; a new read is
      // allowed only if it also fits in FIFO (2) plus output register (1).
      total_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} + {2'b00, rd_en_r}
              + {2'b00, pix_valid_r} - {2'b00, hs_s};
      credit_ok_s = (total_s < 3'd3);

      // Output register: refill from FIFO head first, else bypass the
      // arriving word, else go empty.
      if (load_out_s) begin
         if (fifo_cnt_r != 2'd0) begin
            pix_word_s  = fifo0_r;
            pix_valid_s = 1'b1;
            fifo0_s     = fifo1_r;
            fifo_cnt_s  = fifo_cnt_r - 2'd1;
         end else if (inflight_r) begin
            pix_word_s  = in_word_s;
            pix_valid_s = 1'b1;
            push_s      = 1'b0;
         end else begin
            pix_valid_s = 1'b0;
         end
      end else begin
         pix_valid_s = pix_valid_r;
      end

      // Arriving word not consumed by the output goes to the FIFO tail.
      if (push_s) begin
         if (fifo_cnt_s == 2'd0) begin
            fifo0_s = in_word_s;
         end else begin
            fifo1_s = in_word_s;
         end
         fifo_cnt_s = fifo_cnt_s + 2'd1;
      end else begin
         fifo_cnt_s = fifo_cnt_s;
      end

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s  = ST_READ;
               busy_s   = 1'b1;
               rd_en_s  = 1'b1;
               rd_col_s = 9'd0;
               rd_row_s = 9'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            // rd_col/rd_row always hold the most recently issued address.
            if (at_last_s) begin
               state_s = ST_DRAIN;
            end else if (credit_ok_s) begin
               rd_en_s = 1'b1;
               if (rd_col_r == LAST_IDX) begin
                  rd_col_s = 9'd0;
                  rd_row_s = rd_row_r + 9'd1;
               end else begin
                  rd_col_s = rd_col_r + 9'd1;
               end
            end else begin
               rd_en_s = 1'b0;
            end
         end
         ST_DRAIN: begin
            // Last handshake: nothing left behind the output register.
            if (hs_s && (fifo_cnt_r == 2'd0) && !inflight_r && !rd_en_r) begin
               state_s      = ST_DONE;
               busy_s       = 1'b0;
               frame_done_s = 1'b1;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset discards progress and any in-flight read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         rd_en_r      <= 1'b0;
         rd_col_r     <= 9'd0;
         rd_row_r     <= 9'd0;
         inflight_r   <= 1'b0;
         tag_col_r    <= 9'd0;
         tag_row_r    <= 9'd0;
         fifo0_r      <= 28'd0;
         fifo1_r      <= 28'd0;
         fifo_cnt_r   <= 2'd0;
         pix_valid_r  <= 1'b0;
         pix_word_r   <= 28'd0;
      end else begin
         state_r      <= state_s;
         busy_r       <= busy_s;
         frame_done_r <= frame_done_s;
         rd_en_r      <= rd_en_s;
         rd_col_r     <= rd_col_s;
         rd_row_r     <= rd_row_s;
         inflight_r   <= rd_en_r;
         tag_col_r    <= rd_col_r;
         tag_row_r    <= rd_row_r;
         fifo0_r      <= fifo0_s;
         fifo1_r      <= fifo1_s;
         fifo_cnt_r   <= fifo_cnt_s;
         pix_valid_r  <= pix_valid_s;
         pix_word_r   <= pix_word_s;
      end
   end

   assign busy       = busy_r;
   assign frame_done = frame_done_r;
   assign rd_en      = rd_en_r;
   assign rd_col     = rd_col_r;
   assign rd_row     = rd_row_r;
   assign pix_valid  = pix_valid_r;
   assign x          = pix_word_r[27:18];
   assign y          = pix_word_r[17:8];
   assign z          = pix_word_r[7:0];

endmodule
